// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, ALU and
// PC-source codes, the FSM state encoding and the control vector layout.
package cu_pkg;

  localparam int OPW  = 6;
  localparam int ALUW = 3;

  // Instruction opcodes
  localparam logic [OPW-1:0] OP_ADD  = 6'b000000;
  localparam logic [OPW-1:0] OP_SUB  = 6'b000001;
  localparam logic [OPW-1:0] OP_ORI  = 6'b010000;
  localparam logic [OPW-1:0] OP_AND  = 6'b010001;
  localparam logic [OPW-1:0] OP_OR   = 6'b010010;
  localparam logic [OPW-1:0] OP_MOVE = 6'b100000;
  localparam logic [OPW-1:0] OP_SW   = 6'b100110;
  localparam logic [OPW-1:0] OP_LW   = 6'b100111;
  localparam logic [OPW-1:0] OP_BEQ  = 6'b110000;
  localparam logic [OPW-1:0] OP_J    = 6'b111000;
  localparam logic [OPW-1:0] OP_HALT = 6'b111111;

  // ALU operation codes
  localparam logic [ALUW-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUW-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUW-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUW-1:0] ALU_AND = 3'b100;

  // PC source select codes
  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_IF     = 4'd0,
    ST_ID     = 4'd1,
    ST_EXE_AL = 4'd2,
    ST_EXE_LS = 4'd3,
    ST_EXE_BR = 4'd4,
    ST_MEM    = 4'd5,
    ST_WB_AL  = 4'd6,
    ST_WB_LD  = 4'd7,
    ST_HALT   = 4'd8
  } state_t;

  // Coarse instruction class, used both for sequencing and for ID outputs
  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_MEM,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_t;

  typedef struct packed {
    logic            pc_wre;
    logic            ins_mem_rw;
    logic            ir_wre;
    logic            ext_sel;
    logic            data_mem_rw;
    logic            alu_src_b;
    logic            alu_m2reg;
    logic            reg_wre;
    logic            reg_out;
    logic [1:0]      pc_src;
    logic [ALUW-1:0] alu_op;
    logic            illegal;
    logic            halted;
  } ctrl_t;

  function automatic op_class_t classify(input logic [OPW-1:0] op);
    op_class_t cls;
    case (op)
      OP_ADD, OP_SUB, OP_ORI, OP_AND, OP_OR, OP_MOVE: cls = CLS_ALU;
      OP_SW, OP_LW:                                   cls = CLS_MEM;
      OP_BEQ:                                         cls = CLS_BRANCH;
      OP_J:                                           cls = CLS_JUMP;
      OP_HALT:                                        cls = CLS_HALT;
      default:                                        cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  function automatic logic [ALUW-1:0] alu_code(input logic [OPW-1:0] op);
    logic [ALUW-1:0] code;
    case (op)
      OP_SUB:        code = ALU_SUB;
      OP_ORI, OP_OR: code = ALU_OR;
      OP_AND:        code = ALU_AND;
      default:       code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational control decoder: maps the current FSM state and the
// opcode in force for that state onto the datapath control vector.
module cu_decode
  import cu_pkg::*;
(
  input  state_t           state,
  input  logic [OPW-1:0]   op,
  input  logic             zero,
  input  logic             mem_done,
  output ctrl_t            ctrl
);

  // Everything defaults low; each state raises only the controls it owns
  always_comb begin
    ctrl = '0;
    case (state)
      ST_IF: begin
        ctrl.ins_mem_rw = 1'b1;
        ctrl.ir_wre     = 1'b1;
      end
      ST_ID: begin
        case (classify(op))
          CLS_JUMP: begin
            ctrl.pc_wre = 1'b1;
            ctrl.pc_src = PC_JUMP;
          end
          CLS_ILLEGAL: begin
            ctrl.illegal = 1'b1;
            ctrl.pc_wre  = 1'b1;
            ctrl.pc_src  = PC_NEXT;
          end
          default: ;
        endcase
      end
      ST_EXE_AL: begin
        ctrl.alu_op    = alu_code(op);
        ctrl.alu_src_b = (op == OP_ORI);
      end
      ST_WB_AL: begin
        ctrl.reg_wre = 1'b1;
        ctrl.reg_out = (op != OP_ORI);
        ctrl.pc_wre  = 1'b1;
        ctrl.pc_src  = PC_NEXT;
      end
      ST_EXE_LS: begin
        ctrl.alu_op    = ALU_ADD;
        ctrl.alu_src_b = 1'b1;
        ctrl.ext_sel   = 1'b1;
      end
      ST_MEM: begin
        ctrl.alu_op      = ALU_ADD;
        ctrl.alu_src_b   = 1'b1;
        ctrl.ext_sel     = 1'b1;
        ctrl.data_mem_rw = (op == OP_SW);
        ctrl.pc_wre      = (op == OP_SW) && mem_done;
        ctrl.pc_src      = PC_NEXT;
      end
      ST_WB_LD: begin
        ctrl.reg_wre   = 1'b1;
        ctrl.alu_m2reg = 1'b1;
        ctrl.reg_out   = 1'b0;
        ctrl.pc_wre    = 1'b1;
        ctrl.pc_src    = PC_NEXT;
      end
      ST_EXE_BR: begin
        ctrl.alu_op  = ALU_SUB;
        ctrl.ext_sel = 1'b1;
        ctrl.pc_wre  = 1'b1;
        ctrl.pc_src  = zero ? PC_BRANCH : PC_NEXT;
      end
      ST_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_cu.sv
// Multi-cycle control unit for the MIPS-subset CPU. Sequences each
// instruction through IF/ID/EXE/MEM/WB and drives the datapath controls.
// Optional macro CU_PERF_CNT_EN adds instr_retired and cycle_cnt counters.
module multi_cycle_cu
  import cu_pkg::*;
#(
  parameter int OP_W            = 6,
  parameter int ALUOP_W         = 3,
  parameter int MEM_WAIT_EN_DEF = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWre,
  output logic               InsMemRW,
  output logic               IRWre,
  output logic               ExtSel,
  output logic               DataMemRW,
  output logic               ALUSrcB,
  output logic               ALUM2Reg,
  output logic               RegWre,
  output logic               RegOut,
  output logic [1:0]         PCSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               illegal,
  output logic               halted
`ifdef CU_PERF_CNT_EN
  ,
  output logic [31:0]        instr_retired,
  output logic [31:0]        cycle_cnt
`endif
);

  state_t         state;
  state_t         next_state;
  logic [OPW-1:0] op_now;
  logic [OPW-1:0] op_q;
  logic [OPW-1:0] op_dec;
  logic           mem_done;
  ctrl_t          ctrl;

  assign op_now   = OPW'(op);
  assign op_dec   = (state == ST_ID) ? op_now : op_q;
  assign mem_done = (MEM_WAIT_EN_DEF == 0) ? 1'b1 : mem_ready;

  // State register; reset drops straight back to fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IF;
    end else begin
      state <= next_state;
    end
  end

  // Latch the opcode as the FSM leaves decode so later states see a stable value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
    end else if (state == ST_ID) begin
      op_q <= op_now;
    end
  end

  // Next-state sequencing
  always_comb begin
    next_state = ST_IF;
    case (state)
      ST_IF: next_state = ST_ID;
      ST_ID: begin
        case (classify(op_now))
          CLS_ALU:    next_state = ST_EXE_AL;
          CLS_MEM:    next_state = ST_EXE_LS;
          CLS_BRANCH: next_state = ST_EXE_BR;
          CLS_HALT:   next_state = ST_HALT;
          default:    next_state = ST_IF;
        endcase
      end
      ST_EXE_AL: next_state = ST_WB_AL;
      ST_EXE_LS: next_state = ST_MEM;
      ST_EXE_BR: next_state = ST_IF;
      ST_MEM: begin
        if (!mem_done) begin
          next_state = ST_MEM;
        end else if (op_q == OP_SW) begin
          next_state = ST_IF;
        end else begin
          next_state = ST_WB_LD;
        end
      end
      ST_WB_AL: next_state = ST_IF;
      ST_WB_LD: next_state = ST_IF;
      ST_HALT:  next_state = ST_HALT;
      default:  next_state = ST_IF;
    endcase
  end

  cu_decode u_decode (
    .state    (state),
    .op       (op_dec),
    .zero     (zero),
    .mem_done (mem_done),
    .ctrl     (ctrl)
  );

  assign PCWre     = ctrl.pc_wre;
  assign InsMemRW  = ctrl.ins_mem_rw;
  assign IRWre     = ctrl.ir_wre;
  assign ExtSel    = ctrl.ext_sel;
  assign DataMemRW = ctrl.data_mem_rw;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUM2Reg  = ctrl.alu_m2reg;
  assign RegWre    = ctrl.reg_wre;
  assign RegOut    = ctrl.reg_out;
  assign PCSrc     = ctrl.pc_src;
  assign ALUOp     = ALUOP_W'(ctrl.alu_op);
  assign illegal   = ctrl.illegal;
  assign halted    = ctrl.halted;

`ifdef CU_PERF_CNT_EN
  // Free-running cycle counter (frozen in HALT) and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt     <= '0;
      instr_retired <= '0;
    end else begin
      if (state != ST_HALT) begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end
      if (ctrl.pc_wre || (state == ST_ID && next_state == ST_HALT)) begin
        instr_retired <= instr_retired + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_multi_cycle_cu.sv
// Testbench for multi_cycle_cu: per-cycle vector table plus hand-written
// sequences for memory wait, HALT, and reset aborting an instruction.
module tb_multi_cycle_cu;

  localparam logic [5:0] ADD  = 6'b000000;
  localparam logic [5:0] SUB  = 6'b000001;
  localparam logic [5:0] ORI  = 6'b010000;
  localparam logic [5:0] AND_ = 6'b010001;
  localparam logic [5:0] OR_  = 6'b010010;
  localparam logic [5:0] MOVE = 6'b100000;
  localparam logic [5:0] SW   = 6'b100110;
  localparam logic [5:0] LW   = 6'b100111;
  localparam logic [5:0] BEQ  = 6'b110000;
  localparam logic [5:0] JMP  = 6'b111000;
  localparam logic [5:0] HLT  = 6'b111111;
  localparam logic [5:0] BAD  = 6'b101010;

  typedef struct packed {
    logic       pc_wre;
    logic       ins_mem_rw;
    logic       ir_wre;
    logic       ext_sel;
    logic       data_mem_rw;
    logic       alu_src_b;
    logic       alu_m2reg;
    logic       reg_wre;
    logic       reg_out;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       illegal;
    logic       halted;
  } exp_t;

  typedef struct {
    logic [5:0] op;
    logic       zero;
    logic       rdy;
    exp_t       exp;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       PCWre, InsMemRW, IRWre, ExtSel, DataMemRW, ALUSrcB;
  logic       ALUM2Reg, RegWre, RegOut, illegal, halted;
  logic [1:0] PCSrc;
  logic [2:0] ALUOp;

  int   checks;
  int   failures;
  vec_t vecs[$];
  exp_t e_if, e_zero, e_ill, e_halt;

  multi_cycle_cu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .zero      (zero),
    .mem_ready (mem_ready),
    .PCWre     (PCWre),
    .InsMemRW  (InsMemRW),
    .IRWre     (IRWre),
    .ExtSel    (ExtSel),
    .DataMemRW (DataMemRW),
    .ALUSrcB   (ALUSrcB),
    .ALUM2Reg  (ALUM2Reg),
    .RegWre    (RegWre),
    .RegOut    (RegOut),
    .PCSrc     (PCSrc),
    .ALUOp     (ALUOp),
    .illegal   (illegal),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t ctl(input logic pcw, input logic ext, input logic dmw,
                               input logic srcb, input logic m2r, input logic rw,
                               input logic ro, input logic [1:0] pcs,
                               input logic [2:0] alu);
    exp_t e;
    e = '0;
    e.pc_wre      = pcw;
    e.ext_sel     = ext;
    e.data_mem_rw = dmw;
    e.alu_src_b   = srcb;
    e.alu_m2reg   = m2r;
    e.reg_wre     = rw;
    e.reg_out     = ro;
    e.pc_src      = pcs;
    e.alu_op      = alu;
    return e;
  endfunction

  task automatic add(input logic [5:0] o, input logic z, input logic r, input exp_t e);
    vec_t v;
    v.op   = o;
    v.zero = z;
    v.rdy  = r;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input logic [5:0] o, input logic z, input logic r);
    op        = o;
    zero      = z;
    mem_ready = r;
    #1;
  endtask

  task automatic check_output(input string name, input exp_t exp);
    exp_t act;
    act = {PCWre, InsMemRW, IRWre, ExtSel, DataMemRW, ALUSrcB, ALUM2Reg,
           RegWre, RegOut, PCSrc, ALUOp, illegal, halted};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic check_value(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  initial begin
    int cnt;
    bit done;
    exp_t e_wb_al, e_wb_ori, e_ls, e_mem_sw, e_mem_lw, e_wb_ld;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    op       = ADD;
    zero     = 1'b0;
    mem_ready = 1'b0;

    e_zero = '0;
    e_if   = '0; e_if.ins_mem_rw = 1'b1; e_if.ir_wre = 1'b1;
    e_ill  = '0; e_ill.illegal = 1'b1; e_ill.pc_wre = 1'b1;
    e_halt = '0; e_halt.halted = 1'b1;
    e_wb_al  = ctl(1, 0, 0, 0, 0, 1, 1, 2'b00, 3'b000);
    e_wb_ori = ctl(1, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000);
    e_ls     = ctl(0, 1, 0, 1, 0, 0, 0, 2'b00, 3'b000);
    e_mem_sw = ctl(1, 1, 1, 1, 0, 0, 0, 2'b00, 3'b000);
    e_mem_lw = ctl(0, 1, 0, 1, 0, 0, 0, 2'b00, 3'b000);
    e_wb_ld  = ctl(1, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000);

    // One record per clock cycle: IF, ID, EXE..., WB
    add(ADD, 0, 0, e_if); add(ADD, 0, 1, e_zero);
    add(ADD, 0, 1, ctl(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000)); add(ADD, 0, 0, e_wb_al);
    add(SUB, 0, 0, e_if); add(SUB, 0, 0, e_zero);
    add(SUB, 1, 0, ctl(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b001)); add(SUB, 0, 0, e_wb_al);
    add(ORI, 0, 0, e_if); add(ORI, 0, 0, e_zero);
    add(SUB, 0, 0, ctl(0, 0, 0, 1, 0, 0, 0, 2'b00, 3'b011)); add(SUB, 0, 0, e_wb_ori);
    add(AND_, 0, 0, e_if); add(AND_, 0, 0, e_zero);
    add(AND_, 0, 0, ctl(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b100)); add(AND_, 0, 0, e_wb_al);
    add(OR_, 0, 0, e_if); add(OR_, 0, 0, e_zero);
    add(OR_, 0, 0, ctl(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b011)); add(OR_, 0, 0, e_wb_al);
    add(MOVE, 0, 0, e_if); add(MOVE, 0, 0, e_zero);
    add(MOVE, 0, 0, ctl(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000)); add(MOVE, 0, 0, e_wb_al);
    add(SW, 0, 1, e_if); add(SW, 0, 1, e_zero); add(SW, 0, 0, e_ls); add(SW, 0, 1, e_mem_sw);
    add(LW, 0, 0, e_if); add(LW, 0, 0, e_zero); add(LW, 0, 0, e_ls);
    add(LW, 0, 1, e_mem_lw); add(LW, 0, 0, e_wb_ld);
    add(BEQ, 1, 0, e_if); add(BEQ, 1, 0, e_zero);
    add(BEQ, 1, 0, ctl(1, 1, 0, 0, 0, 0, 0, 2'b01, 3'b001));
    add(BEQ, 0, 0, e_if); add(BEQ, 0, 0, e_zero);
    add(BEQ, 0, 0, ctl(1, 1, 0, 0, 0, 0, 0, 2'b00, 3'b001));
    add(JMP, 0, 0, e_if); add(JMP, 0, 0, ctl(1, 0, 0, 0, 0, 0, 0, 2'b10, 3'b000));
    add(BAD, 0, 0, e_if); add(BAD, 0, 0, e_ill);

    // Reset held: only the fetch enables are high
    @(negedge clk);
    apply_stimulus(HLT, 1, 1);
    check_output("reset_held", e_if);
    @(negedge clk);
    apply_stimulus(SW, 0, 1);
    check_output("reset_held2", e_if);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].op, vecs[i].zero, vecs[i].rdy);
      check_output($sformatf("vec%0d", i), vecs[i].exp);
      @(negedge clk);
    end

    // HALT: stays put for 100 cycles regardless of mem_ready
    apply_stimulus(HLT, 0, 0);
    check_output("halt_if", e_if);
    @(negedge clk);
    apply_stimulus(HLT, 0, 0);
    check_output("halt_id", e_zero);
    @(negedge clk);
    for (int k = 0; k < 100; k++) begin
      apply_stimulus(HLT, k[1], k[0]);
      check_output($sformatf("halt_c%0d", k), e_halt);
      @(negedge clk);
    end
    apply_stimulus(ADD, 0, 0);
    rst_n = 1'b0;
    #1;
    check_output("halt_reset_exit", e_if);
    @(negedge clk);
    rst_n = 1'b1;

    // SW aborted by reset while in MEM
    apply_stimulus(SW, 0, 0); check_output("sw_abort_if", e_if);  @(negedge clk);
    apply_stimulus(SW, 0, 0); check_output("sw_abort_id", e_zero); @(negedge clk);
    apply_stimulus(SW, 0, 0); check_output("sw_abort_exe", e_ls);  @(negedge clk);
    apply_stimulus(SW, 0, 0);
    check_output("sw_abort_mem_wait", ctl(0, 1, 1, 1, 0, 0, 0, 2'b00, 3'b000));
    #1;
    rst_n = 1'b0;
    #1;
    check_output("sw_abort_reset", e_if);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(SW, 0, 1);
    check_output("sw_abort_refetch", e_if);
    @(negedge clk);
    apply_stimulus(SW, 0, 1);
    check_output("sw_abort_id_after", e_zero);
    @(negedge clk);
    apply_stimulus(SW, 0, 1);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);

    // LW with mem_ready low for the first two MEM cycles
    cnt  = 0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      apply_stimulus(LW, 0, (k >= 5) ? 1'b1 : 1'b0);
      if (k > 0 && IRWre) begin
        done = 1'b1;
        cnt  = k;
      end else if (k >= 3 && k <= 5) begin
        check_output($sformatf("lw_mem_c%0d", k), e_mem_lw);
      end else if (k == 6) begin
        check_output("lw_wb_ld", e_wb_ld);
      end
      if (!done) @(negedge clk);
    end
    check_value("lw_wait_cycles", cnt, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
